// File: rtl/trace_streamer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_streamer_pkg : shared record format and serializer constants
// Revision: 1.0
// ---------------------------------------------------------------------------
package trace_streamer_pkg;

    localparam logic [7:0] HDR_REG   = 8'hA1;
    localparam logic [7:0] HDR_MEM   = 8'hA2;
    localparam int         REC_BYTES = 13;
    localparam logic [3:0] LAST_BYTE = 4'(REC_BYTES - 1);

    typedef enum logic {
        REC_REG = 1'b0,
        REC_MEM = 1'b1
    } rec_type_e;

    typedef struct packed {
        rec_type_e   typ;
        logic [31:0] pc;
        logic [31:0] key;
        logic [31:0] data;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);
    localparam int SER_W = REC_BYTES * 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    // Byte 0 sits in the low bits so the stream is emitted LSB-first.
    function automatic logic [SER_W-1:0] serialize(input trace_rec_t rec);
        logic [7:0] hdr;
        hdr = (rec.typ == REC_REG) ? HDR_REG : HDR_MEM;
        return {rec.data, rec.key, rec.pc, hdr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_fifo : commit-record FIFO with wrap-bit pointers
// Revision: 1.0
// ---------------------------------------------------------------------------
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 97
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/trace_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_streamer : captures commit events and streams them as 13-byte records
// Revision: 1.0
// ---------------------------------------------------------------------------
module trace_streamer
    import trace_streamer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_en,
    input  logic [31:0] pc,
    input  logic        reg_we,
    input  logic [4:0]  rd,
    input  logic [31:0] rd_wdata,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [7:0]  drop_cnt,
    output logic        err_both
);

    ser_state_e       r_state;
    logic [3:0]       r_cnt;
    logic [SER_W-1:0] r_shift;
    logic             r_valid;
    logic [7:0]       r_drop;
    logic             r_err;

    trace_rec_t w_rec;
    trace_rec_t w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_accept;
    logic       w_pop;
    logic       w_last_hs;

    // REG takes priority when both write enables fire together.
    always_comb begin
        w_rec.typ  = reg_we ? REC_REG : REC_MEM;
        w_rec.pc   = pc;
        w_rec.key  = reg_we ? {27'b0, rd} : mem_addr;
        w_rec.data = reg_we ? rd_wdata : mem_wdata;
    end

    assign w_push    = trace_en && (reg_we || mem_we);
    assign w_last_hs = (r_state == S_SEND) && out_ready && (r_cnt == LAST_BYTE);
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || w_last_hs);
    assign w_accept  = w_push && (!w_full || w_pop);

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_accept),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= serialize(w_head);
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_cnt == LAST_BYTE) begin
                            r_cnt <= '0;
                            if (!w_empty) begin
                                r_shift <= serialize(w_head);
                            end else begin
                                r_shift <= '0;
                                r_valid <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt   <= r_cnt + 4'd1;
                            r_shift <= {8'h00, r_shift[SER_W-1:8]};
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_push && !w_accept && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
            if (reg_we && mem_we) r_err <= 1'b1;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_shift[7:0];
    assign drop_cnt  = r_drop;
    assign err_both  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_trace_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trace_streamer : vector table plus byte scoreboard for trace_streamer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_trace_streamer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b1;
    logic [31:0] pc = '0;
    logic        reg_we = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] rd_wdata = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [7:0]  drop_cnt;
    logic        err_both;

    int n_chk = 0;
    int n_fail = 0;
    int bytes_seen = 0;
    int rdy_mode = 0;
    logic [7:0] expq[$];

    typedef struct {
        logic        rwe;
        logic        mwe;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rdw;
        logic [31:0] addr;
        logic [31:0] mwd;
        logic [7:0]  hdr;
        logic [31:0] key;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[4];

    trace_streamer #(.DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .trace_en  (trace_en),
        .pc        (pc),
        .reg_we    (reg_we),
        .rd        (rd),
        .rd_wdata  (rd_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .err_both  (err_both)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Every presented byte must match the queue head; it pops on handshake.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            n_chk++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL stream_byte: got %02h required none (queue empty)", out_data);
            end else begin
                if (out_data !== expq[0]) begin
                    n_fail++;
                    $display("FAIL stream_byte: got %02h required %02h", out_data, expq[0]);
                end
                if (out_ready) begin
                    void'(expq.pop_front());
                    bytes_seen++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input logic rwe, input logic mwe, input logic [31:0] p,
                          input logic [4:0] r, input logic [31:0] rw,
                          input logic [31:0] a, input logic [31:0] mw);
        reg_we = rwe; mem_we = mwe; pc = p; rd = r;
        rd_wdata = rw; mem_addr = a; mem_wdata = mw;
    endtask

    task automatic clr_ev();
        reg_we = 1'b0;
        mem_we = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] hdr, input logic [31:0] p,
                            input logic [31:0] k, input logic [31:0] d);
        expq.push_back(hdr);
        for (int i = 0; i < 4; i++) expq.push_back(p[8*i +: 8]);
        for (int i = 0; i < 4; i++) expq.push_back(k[8*i +: 8]);
        for (int i = 0; i < 4; i++) expq.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((expq.size() != 0 || out_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (k >= 3000) begin
            n_fail++;
            $display("FAIL %s: drain timeout, %0d bytes still expected", name, expq.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 5'd5,  32'h0000_0007, 32'h0,      32'h0,
                    8'hA1, 32'h0000_0005, 32'h0000_0007};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0024, 5'd0,  32'h0,         32'h200,    32'hFFFF_FFFC,
                    8'hA2, 32'h0000_0200, 32'hFFFF_FFFC};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 5'd31, 32'hDEAD_BEEF, 32'h55,     32'h66,
                    8'hA1, 32'h0000_001F, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h89AB_CDEF, 5'd0,  32'h1234_5678, 32'h0,      32'h0,
                    8'hA1, 32'h0000_0000, 32'h1234_5678};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        chk("rst_err_both",  32'(err_both),  32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("err_both_clear", 32'(err_both), 32'd0);

        for (int v = 0; v < 4; v++) begin
            tick();
            set_ev(vecs[v].rwe, vecs[v].mwe, vecs[v].pc, vecs[v].rd,
                   vecs[v].rdw, vecs[v].addr, vecs[v].mwd);
            push_exp(vecs[v].hdr, vecs[v].pc, vecs[v].key, vecs[v].data);
            tick();
            clr_ev();
            @(negedge clk);
            chk("latency_not_yet", 32'(out_valid), 32'd0);
            @(negedge clk);
            chk("latency_valid", 32'(out_valid), 32'd1);
            wait_drain("vector_drain");
            chk("valid_drops", 32'(out_valid), 32'd0);
        end
        chk("err_both_sticky", 32'(err_both), 32'd1);

        // MEM record under a toggling sink
        rdy_mode = 1;
        tick();
        set_ev(1'b0, 1'b1, 32'h24, 5'd0, 32'h0, 32'h200, 32'hFFFF_FFFC);
        push_exp(8'hA2, 32'h24, 32'h200, 32'hFFFF_FFFC);
        tick();
        clr_ev();
        wait_drain("toggle_drain");
        rdy_mode = 0;
        tick();

        // Overflow with the sink stalled: 8 in FIFO + 1 in shift register
        rdy_mode = 2;
        tick();
        tick();
        for (int i = 0; i < 12; i++) begin
            set_ev(1'b1, 1'b0, 32'h400 + 32'(i * 4), 5'(i + 1), 32'(i + 100), 32'h0, 32'h0);
            if (i < 9) push_exp(8'hA1, 32'h400 + 32'(i * 4), 32'(i + 1), 32'(i + 100));
            tick();
        end
        clr_ev();
        @(negedge clk);
        chk("drop_cnt_3", 32'(drop_cnt), 32'd3);
        chk("stalled_valid", 32'(out_valid), 32'd1);
        rdy_mode = 0;
        wait_drain("overflow_drain");
        chk("drop_cnt_hold", 32'(drop_cnt), 32'd3);

        // Saturating drop counter, then trace_en=0 drains without capturing
        rdy_mode = 2;
        tick();
        tick();
        for (int i = 0; i < 309; i++) begin
            set_ev(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 5'(i), 32'(i), 32'h0, 32'h0);
            if (i < 9) push_exp(8'hA1, 32'h1000 + 32'(i * 4), 32'(5'(i)), 32'(i));
            tick();
        end
        clr_ev();
        @(negedge clk);
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        trace_en = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 20; i++) begin
            set_ev(1'b1, 1'b0, 32'hBAD0_0000 + 32'(i), 5'd3, 32'hBAD, 32'h0, 32'h0);
            tick();
        end
        clr_ev();
        wait_drain("disabled_drain");
        repeat (5) @(negedge clk);
        chk("disabled_idle", 32'(out_valid), 32'd0);
        chk("drop_cnt_sat_hold", 32'(drop_cnt), 32'd255);
        trace_en = 1'b1;

        // Reset after byte 5 of the first of four back-to-back records
        bytes_seen = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_ev(1'b1, 1'b0, 32'h2000 + 32'(i * 4), 5'(i + 8), 32'hC0 + 32'(i), 32'h0, 32'h0);
            push_exp(8'hA1, 32'h2000 + 32'(i * 4), 32'(i + 8), 32'hC0 + 32'(i));
            tick();
        end
        clr_ev();
        begin
            int k;
            k = 0;
            while (bytes_seen < 6 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("reach_byte5", 32'(bytes_seen >= 6), 32'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data",  32'(out_data),  32'd0);
        chk("midrst_drop",  32'(drop_cnt),  32'd0);
        chk("midrst_err",   32'(err_both),  32'd0);
        tick();
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("fifo_flushed", 32'(out_valid), 32'd0);
        tick();
        set_ev(1'b1, 1'b0, 32'h0000_0010, 5'd5, 32'h7, 32'h0, 32'h0);
        push_exp(8'hA1, 32'h10, 32'h5, 32'h7);
        tick();
        clr_ev();
        @(negedge clk);
        chk("post_rst_latency0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_latency1", 32'(out_valid), 32'd1);
        chk("post_rst_byte0", 32'(out_data), 32'hA1);
        wait_drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_streamer.md
TRACE_STREAMER -- requirements
Module: trace_streamer

Interface
REQ-001 Parameter DEPTH, default 8: commit-record FIFO depth; power of two, minimum 2.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 trace_en  in  1  high: commit events are captured; low: events are ignored.
REQ-005 pc  in  32  PC of the instruction retiring this cycle.
REQ-006 reg_we  in  1  register write-back this cycle (REG event).
REQ-007 rd  in  5  destination register index.
REQ-008 rd_wdata  in  32  write-back data.
REQ-009 mem_we  in  1  store this cycle (MEM event).
REQ-010 mem_addr  in  32  store address (ALU result).
REQ-011 mem_wdata  in  32  store data (rs2).
REQ-012 out_valid  out  1  stream byte valid.
REQ-013 out_ready  in  1  sink accepts the byte.
REQ-014 out_data  out  8  stream byte.
REQ-015 drop_cnt  out  8  dropped-event count, saturating.
REQ-016 err_both  out  1  sticky flag: reg_we and mem_we were high in the same cycle.

Function
REQ-017 Each rising edge with trace_en=1 and reg_we=1 SHALL push record {type=REG, pc, key={27'b0,rd}, data=rd_wdata}.
REQ-018 Each rising edge with trace_en=1, mem_we=1 and reg_we=0 SHALL push record {type=MEM, pc, key=mem_addr, data=mem_wdata}.
REQ-019 When reg_we and mem_we are both high, only the REG record SHALL be pushed and err_both SHALL set.
REQ-020 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-021 A rejected push SHALL be discarded; drop_cnt SHALL increment and saturate at 255; FIFO contents SHALL be unchanged.
REQ-022 Each record SHALL be serialized as 13 bytes: byte0 = 0xA1 (REG) or 0xA2 (MEM); bytes1-4 = pc; bytes5-8 = key; bytes9-12 = data; all fields little-endian.
REQ-023 Serializer FSM states: IDLE and SEND, with a 4-bit byte counter.
REQ-024 IDLE: out_valid=0. If the FIFO is non-empty, the head SHALL be popped into the shift register, the counter set to 0, and the FSM SHALL move to SEND.
REQ-025 SEND: out_valid=1. On handshake (out_valid & out_ready) the counter SHALL increment.
REQ-026 On the handshake of byte 12, the FSM SHALL pop the next record and stay in SEND with counter 0 if the FIFO is non-empty; otherwise it SHALL return to IDLE.
REQ-027 While out_valid=1 and out_ready=0, out_data and the counter SHALL hold stable.
REQ-028 Latency: an event sampled at edge N SHALL produce out_valid=1 after edge N+1 (FIFO empty, FSM IDLE).
REQ-029 Read and write pointers SHALL carry log2(DEPTH)+1 bits with wrap-around.
REQ-029 (cont.) Full = MSBs differ and low bits are equal; empty = pointers equal.
REQ-030 trace_en=0 SHALL NOT stop serialization of records already in the FIFO.

Reset
REQ-031 While reset=0: FSM=IDLE, pointers=0, counter=0, out_valid=0, out_data=0, drop_cnt=0, err_both=0.
REQ-032 Reset mid-record SHALL abandon the partial record and flush the FIFO. There is no resume.

Structure
REQ-033 Shared package SHALL hold: header constants (0xA1, 0xA2), record length 13, and the record struct/width (type 1 bit, pc 32, key 32, data 32).
REQ-034 The FIFO SHALL be a sub-module named trace_fifo, parameterized by DEPTH and width; the FSM and serializer SHALL live in trace_streamer.

Verification
REQ-035 One REG event (pc=0x00000010, rd=5, rd_wdata=7), out_ready=1 -> bytes A1 10 00 00 00 05 00 00 00 07 00 00 00; out_valid drops after byte 12.
REQ-036 MEM event (pc=0x24, addr=0x200, data=0xFFFFFFFC), out_ready toggling 1/0 -> the same 13 bytes with A2 header; each byte held stable while stalled.
REQ-037 DEPTH=8, out_ready=0, 12 consecutive REG events -> 9 records accepted (8 in FIFO + 1 in shift register), drop_cnt=3; releasing out_ready yields 9 records in order.
REQ-038 reg_we=1 and mem_we=1 in one cycle -> only a REG record is emitted; err_both=1 until reset.
REQ-039 Assert reset=0 after byte 5 of a record with 3 records queued -> out_valid=0 and the FIFO is empty. The next event after release streams from byte0.
REQ-040 300 dropped events -> drop_cnt=255; trace_en=0 with pending records -> all pending records drain and no new records are captured.
